cmp_seq: RTL and testbench
==========================

# cmp_seq

Parametrised multi-cycle magnitude comparator for the datapath compare unit. Compares two `WIDTH`-bit operands `SLICE` bits per clock, MSB slice first, in signed or unsigned mode, under a start/busy/done handshake. Result uses the existing compare encoding: greater `2'b10`, equal `2'b01`, less `2'b00`. It replaces the single-cycle comparator where a wide operand would otherwise set the critical path.

## Interface
Parameters:
- `WIDTH`, 32: operand width in bits; must be a multiple of `SLICE`.
- `SLICE`, 8: bits compared per cycle; `N = WIDTH/SLICE` slices.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while idle.
- `a`  in  `WIDTH`  operand A; captured on the accepting edge.
- `b`  in  `WIDTH`  operand B; captured on the accepting edge.
- `is_signed`  in  1  1 = two's-complement compare, 0 = unsigned; captured with operands.
- `busy`  out  1  high while a compare is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle on.
- `result`  out  2  `10` A>B, `01` A==B, `00` A<B; held until the next `done`.

## Operation
- States: IDLE, RUN.
- IDLE: when `start`=1 at an edge, latch `a`, `b`, `is_signed`, set slice index `idx = N-1` and `busy=1`, then go to RUN. When `start`=0, stay in IDLE.
- RUN: each edge compares slice `idx` of the latched A and B as unsigned `SLICE`-bit values.
  - In signed mode, invert the MSB of both operands for the top slice (`idx = N-1`) only.
  - The first slice where A and B differ decides the outcome: `10` if A's slice is larger, `00` otherwise.
  - If no slice differs, the outcome is `01`.
- Finish: on the edge that resolves the outcome, register `result`, pulse `done=1`, drop `busy`, and return to IDLE. Decrement `idx` otherwise.
- `start` while busy is ignored. Input operands may change freely after acceptance.
- A new `start` is accepted in the same cycle `done` is high, because the block is already in IDLE.
- Reset (any time, including mid-RUN): state IDLE, `busy=0`, `done=0`, `result=2'b00`, `idx=0`, latched operands cleared. The aborted compare produces no `done`.

## Timing
- Accepting edge E0; slice comparisons happen at E1..EN.
- Worst-case latency: `done` is high in the cycle after edge EN, N cycles after E0.
- Early exit (see Configuration): `done` is high after edge Ek, where k (1..N) is the position of the first differing slice counted from the MSB.
- `busy` is high from after E0 up to and including the resolving edge. It is low whenever `done` is high.
- `done` is exactly one cycle wide. `result` changes only on the edge that raises `done`, or on reset.
- Back-to-back: with `start` held high, a compare is accepted every N+1 cycles in the worst case.

## Configuration
- `CMP_EARLY_EXIT_EN` defined: RUN terminates at the first differing slice, so latency is k cycles.
- Not defined: all N slices are always processed. The first difference is recorded in a sticky flag and later slices do not change it. Latency is fixed at N cycles. Results are identical in both builds.

## Test plan
All scenarios use WIDTH=32, SLICE=8, N=4.
- a=5, b=5, unsigned, start one cycle -> `result=01`, `done` pulse 4 cycles after accept, `busy` high for cycles 1-4.
- a=0x80000000, b=0x00000001, unsigned -> `result=10`; `done` 1 cycle after accept with `CMP_EARLY_EXIT_EN`, 4 cycles without.
- Same operands with `is_signed=1` -> `result=00`. Then a=0xFFFFFFFF, b=0xFFFFFFFE, signed -> `result=10` after 4 cycles.
- a=0x12345600, b=0x12345601, unsigned -> `result=00` after 4 cycles in both builds. While busy, pulse `start` with a=9, b=1 -> ignored; the first result is unaffected.
- Start a compare, assert `reset` low at cycle 2 -> `busy`, `done` and `result` immediately 0, no `done` pulse. After release, a=7, b=3 -> `result=10`.
- Hold `start` high with a=b=0 for 12 cycles -> `done` pulses every 5 cycles, `result=01`, `busy` never high together with `done`.

Source files
------------

// File: rtl/cmp_seq_if.sv
// Request/response bundle for the sequential magnitude comparator cmp_seq.
// The requester uses the master modport; cmp_seq uses the slave modport.
interface cmp_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic [1:0]       result;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, result
  );
endinterface

// File: rtl/cmp_seq.sv
// Multi-cycle magnitude comparator: SLICE bits per clock, MSB slice first.
// Define CMP_EARLY_EXIT_EN to stop at the first differing slice instead of always scanning all N.
module cmp_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic     clk,
  input  logic     reset,
  cmp_seq_if.slave bus,
  output logic     dbg_state
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is sampled only in IDLE and the operands are captured on that edge.
  // busy is high while slices are being compared. done is a one-cycle pulse, raised while
  // already back in IDLE, so a new start can be accepted in that same cycle.
  // result is held from done until the next done.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [1:0]       result_q;
  logic             done_q;
`ifndef CMP_EARLY_EXIT_EN
  logic             sticky_q;
  logic [1:0]       sticky_res_q;
`endif

  logic [SLICE-1:0] sa, sb;
  logic             top, bottom, diff, finish;
  logic [1:0]       slice_res, outcome;
  int               sh;

  always_comb begin
    sh     = int'(idx_q) * SLICE;
    top    = (idx_q == IW'(N - 1));
    bottom = (idx_q == '0);
    sa     = a_q[sh +: SLICE];
    sb     = b_q[sh +: SLICE];
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    if (sgn_q && top) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
    diff      = (sa != sb);
    slice_res = (sa > sb) ? 2'b10 : 2'b00;
`ifdef CMP_EARLY_EXIT_EN
    finish  = diff || bottom;
    outcome = diff ? slice_res : 2'b01;
`else
    finish  = bottom;
    outcome = sticky_q ? sticky_res_q : (diff ? slice_res : 2'b01);
`endif
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (finish)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sgn_q        <= 1'b0;
      result_q     <= 2'b00;
      done_q       <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      sticky_q     <= 1'b0;
      sticky_res_q <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q          <= bus.a;
            b_q          <= bus.b;
            sgn_q        <= bus.is_signed;
            idx_q        <= IW'(N - 1);
`ifndef CMP_EARLY_EXIT_EN
            sticky_q     <= 1'b0;
            sticky_res_q <= 2'b00;
`endif
          end
        end
        RUN: begin
          if (finish) begin
            result_q <= outcome;
            done_q   <= 1'b1;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
`ifndef CMP_EARLY_EXIT_EN
          // Only the most significant differing slice may decide the outcome.
          if (diff && !sticky_q) begin
            sticky_q     <= 1'b1;
            sticky_res_q <= slice_res;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Self-checking bench for cmp_seq (WIDTH=32, SLICE=8): directed scenarios plus random
// operands against a reference built from signed/unsigned integer comparison.
module tb_cmp_seq;

  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  logic clk;
  logic reset;
  logic dbg_state;
  int   n_checks;
  int   n_fail;
  logic [1:0] exp_q[$];

  cmp_seq_if #(.WIDTH(W)) bus ();

  cmp_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    if (sgn) begin
      if ($signed(a) > $signed(b)) return 2'b10;
      if ($signed(a) < $signed(b)) return 2'b00;
      return 2'b01;
    end
    if (a > b) return 2'b10;
    if (a < b) return 2'b00;
    return 2'b01;
  endfunction

  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int k = 1; k <= N; k++) begin
      if (((a >> ((N - k) * S)) & 32'hFF) != ((b >> ((N - k) * S)) & 32'hFF)) return k;
    end
    return N;
`else
    if (a == b) return N;
    return N;
`endif
  endfunction

  // ---------------- driver ----------------
  // Runs one compare; if pulse_at > 0 a stray start with a=9,b=1 is driven mid-run.
  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string tag, input int pulse_at);
    int lat;
    bit got;
    logic [1:0] exp_res;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.is_signed = sgn;
    exp_q.push_back(ref_result(a, b, sgn));
    lat = ref_latency(a, b);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.is_signed = 1'($urandom_range(0, 1));
    check({tag, "_busy_c0"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_done_c0"}, {31'd0, bus.done}, 32'd0);
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        exp_res = exp_q.pop_front();
        check({tag, "_latency"}, c, lat);
        check({tag, "_result"}, {30'd0, bus.result}, {30'd0, exp_res});
        check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      end else begin
        check({tag, "_busy_run"}, {31'd0, bus.busy}, 32'd1);
        if (c == pulse_at) begin
          bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd1; bus.is_signed = 1'b0;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_width"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_result_hold"}, {30'd0, bus.result}, {30'd0, exp_res});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          dones;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", {30'd0, bus.result}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b1;

    run_cmp(32'd5, 32'd5, 1'b0, "eq5", 0);
    run_cmp(32'h80000000, 32'h00000001, 1'b0, "msb_uns", 0);
    run_cmp(32'h80000000, 32'h00000001, 1'b1, "msb_sgn", 0);
    run_cmp(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "neg_sgn", 0);
    run_cmp(32'h12345600, 32'h12345601, 1'b0, "lsb_ign", 2);

    // Abort mid-run: outputs clear immediately and no done follows.
    run_cmp(32'h00000080, 32'h00000001, 1'b0, "pre_rst", 0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h55; bus.b = 32'h55; bus.is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    check("abort_state_before", {31'd0, dbg_state}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_result", {30'd0, bus.result}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_cmp(32'd7, 32'd3, 1'b0, "after_rst", 0);

    // Back-to-back with start held high: done on cycles 5 and 10.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd0; bus.b = 32'd0; bus.is_signed = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_done", {31'd0, bus.done}, {31'd0, (c % (N + 1)) == 0});
      check("b2b_excl", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) check("b2b_result", {30'd0, bus.result}, 32'd1);
    end
    bus.start = 1'b0;
    for (int c = 0; c < 20 && bus.busy; c++) @(negedge clk);
    check("b2b_drain", {31'd0, bus.busy}, 32'd0);

    // Random operands with biased patterns (equal, single-bit difference, negatives).
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ;
        1: rb = ra;
        2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: begin
          ra = ra | 32'h80000000;
          rb = ($urandom_range(0, 1) != 0) ? (rb | 32'h80000000) : (ra ^ 32'h00000100);
        end
      endcase
      run_cmp(ra, rb, rs, "rand", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
